// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg
// Shared definitions for the PSRAM round-robin arbiter: FSM state encoding,
// bus widths, the error read-data pattern and a small index-to-one-hot helper.
// No ports (package).
package psram_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int IDX_W  = 2;

  // Read data returned to a requester whose transaction hit the watchdog
  localparam logic [DATA_W-1:0] ERR_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Requester index to a 4-bit one-hot vector (callers slice to NUM_REQ)
  function automatic logic [3:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    return oh;
  endfunction

endpackage

// File: rtl/psram_arb_if.sv
// psram_arb_if
// Bundles the requester-side native bus, the PSRAM controller port and the
// error/status signals of the arbiter.
//   req_valid_i/addr/wdata/wstrb : packed per-requester request fields
//   req_ready_o/req_rdata_o      : one-hot completion pulse and read data
//   mem_*                        : single downstream PSRAM controller port
//   err_o/err_id_o/err_clr_i     : sticky watchdog error flag, id and clear
// Modport master is the arbiter's view; slave is the surrounding SoC's view.
interface psram_arb_if
  import psram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ*STRB_W-1:0] req_wstrb_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [DATA_W-1:0]         req_rdata_o;

  logic                      mem_valid_o;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic [DATA_W-1:0]         mem_wdata_o;
  logic [STRB_W-1:0]         mem_wstrb_o;
  logic                      mem_ready_i;
  logic [DATA_W-1:0]         mem_rdata_i;

  logic                      err_o;
  logic [IDX_W-1:0]          err_id_o;
  logic                      err_clr_i;

  modport master (
    input  req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i,
    input  mem_ready_i, mem_rdata_i, err_clr_i,
    output req_ready_o, req_rdata_o,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output err_o, err_id_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i,
    output mem_ready_i, mem_rdata_i, err_clr_i,
    input  req_ready_o, req_rdata_o,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  err_o, err_id_o
  );

endinterface

// File: rtl/psram_arb_rr_pick.sv
// rr_pick
// Combinational round-robin selector. Scans the request vector starting at
// (last_i + 1) mod NUM_REQ, wrapping, and returns the first requester found.
//   req_i  : request bits, one per requester
//   last_i : index of the previously served requester
//   any_o  : at least one request is pending
//   idx_o  : selected requester index (0 when any_o is low)
module rr_pick
  import psram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [3:0] req_pad_s;

  assign req_pad_s = 4'(req_i);

  // Scan the priority order backwards so the earliest hit overwrites the rest
  always_comb begin
    logic [IDX_W-1:0] cand_s;
    any_o  = |req_i;
    idx_o  = 2'd0;
    cand_s = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_s = 2'((int'(last_i) + 1 + i) % NUM_REQ);
      idx_o  = req_pad_s[cand_s] ? cand_s : idx_o;
    end
  end

endmodule

// File: rtl/psram_arb.sv
// psram_arb
// Shares one PSRAM controller port between up to four native-bus requesters.
// A round-robin pick in IDLE latches the winner's address/data/strobes, BUSY
// presents them downstream until mem_ready_i or the watchdog expires, and RESP
// returns a one-cycle ready pulse with the captured (or error) read data.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : psram_arb_if master modport (requesters, memory, error)
module psram_arb
  import psram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  psram_arb_if.master bus
);

  state_e              state_r, state_nx_s;
  logic [IDX_W-1:0]    grant_r, grant_nx_s;
  logic [IDX_W-1:0]    last_grant_r, last_grant_nx_s;
  logic [15:0]         wdog_r, wdog_nx_s;
  logic [ADDR_W-1:0]   addr_r, addr_nx_s;
  logic [DATA_W-1:0]   wdata_r, wdata_nx_s;
  logic [STRB_W-1:0]   wstrb_r, wstrb_nx_s;
  logic                mem_valid_r, mem_valid_nx_s;
  logic [NUM_REQ-1:0]  ready_r, ready_nx_s;
  logic [DATA_W-1:0]   rdata_r, rdata_nx_s;
  logic                err_r, err_nx_s;
  logic [IDX_W-1:0]    err_id_r, err_id_nx_s;

  logic                pick_any_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic [3:0]          grant_oh_s;

  // Fields unpacked into 4-entry arrays so a 2-bit index always fits
  logic [ADDR_W-1:0]   addr_arr_s  [4];
  logic [DATA_W-1:0]   wdata_arr_s [4];
  logic [STRB_W-1:0]   wstrb_arr_s [4];

  for (genvar k = 0; k < 4; k++) begin : g_unpack
    if (k < NUM_REQ) begin : g_live
      assign addr_arr_s[k]  = bus.req_addr_i[ADDR_W*k +: ADDR_W];
      assign wdata_arr_s[k] = bus.req_wdata_i[DATA_W*k +: DATA_W];
      assign wstrb_arr_s[k] = bus.req_wstrb_i[STRB_W*k +: STRB_W];
    end else begin : g_pad
      assign addr_arr_s[k]  = 32'h0000_0000;
      assign wdata_arr_s[k] = 32'h0000_0000;
      assign wstrb_arr_s[k] = 4'h0;
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i  (bus.req_valid_i),
    .last_i (last_grant_r),
    .any_o  (pick_any_s),
    .idx_o  (pick_idx_s)
  );

  assign grant_oh_s = idx_onehot(grant_r);

  // Next-state and next-output logic for the IDLE/BUSY/RESP sequence
  always_comb begin
    state_nx_s      = state_r;
    grant_nx_s      = grant_r;
    last_grant_nx_s = last_grant_r;
    wdog_nx_s       = wdog_r;
    addr_nx_s       = addr_r;
    wdata_nx_s      = wdata_r;
    wstrb_nx_s      = wstrb_r;
    mem_valid_nx_s  = 1'b0;
    ready_nx_s      = '0;
    rdata_nx_s      = rdata_r;
    err_nx_s        = err_r & ~bus.err_clr_i;
    err_id_nx_s     = err_id_r;

    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          grant_nx_s     = pick_idx_s;
          addr_nx_s      = addr_arr_s[pick_idx_s];
          wdata_nx_s     = wdata_arr_s[pick_idx_s];
          wstrb_nx_s     = wstrb_arr_s[pick_idx_s];
          wdog_nx_s      = 16'd0;
          mem_valid_nx_s = 1'b1;
          state_nx_s     = ST_BUSY;
        end else begin
          state_nx_s     = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // A real completion on the last watchdog cycle still counts as success
        if (bus.mem_ready_i) begin
          rdata_nx_s = bus.mem_rdata_i;
          ready_nx_s = grant_oh_s[NUM_REQ-1:0];
          state_nx_s = ST_RESP;
        end else if (wdog_r == 16'(TIMEOUT - 1)) begin
          rdata_nx_s  = ERR_RDATA;
          err_nx_s    = 1'b1;
          err_id_nx_s = grant_r;
          ready_nx_s  = grant_oh_s[NUM_REQ-1:0];
          state_nx_s  = ST_RESP;
        end else begin
          wdog_nx_s      = wdog_r + 16'd1;
          mem_valid_nx_s = 1'b1;
          state_nx_s     = ST_BUSY;
        end
      end
      ST_RESP: begin
        last_grant_nx_s = grant_r;
        state_nx_s      = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; last_grant resets so requester 0 wins first
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      grant_r      <= 2'd0;
      last_grant_r <= 2'(NUM_REQ - 1);
      wdog_r       <= 16'd0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      wstrb_r      <= 4'h0;
      mem_valid_r  <= 1'b0;
      ready_r      <= '0;
      rdata_r      <= 32'h0000_0000;
      err_r        <= 1'b0;
      err_id_r     <= 2'd0;
    end else begin
      state_r      <= state_nx_s;
      grant_r      <= grant_nx_s;
      last_grant_r <= last_grant_nx_s;
      wdog_r       <= wdog_nx_s;
      addr_r       <= addr_nx_s;
      wdata_r      <= wdata_nx_s;
      wstrb_r      <= wstrb_nx_s;
      mem_valid_r  <= mem_valid_nx_s;
      ready_r      <= ready_nx_s;
      rdata_r      <= rdata_nx_s;
      err_r        <= err_nx_s;
      err_id_r     <= err_id_nx_s;
    end
  end

  assign bus.req_ready_o = ready_r;
  assign bus.req_rdata_o = rdata_r;
  assign bus.mem_valid_o = mem_valid_r;
  assign bus.mem_addr_o  = addr_r;
  assign bus.mem_wdata_o = wdata_r;
  assign bus.mem_wstrb_o = wstrb_r;
  assign bus.err_o       = err_r;
  assign bus.err_id_o    = err_id_r;

endmodule

// File: tb/tb_psram_arb.sv
// tb_psram_arb
// Directed bench for psram_arb (NUM_REQ=4, TIMEOUT=8). Expected completions
// are queued when a request is issued and popped when a ready pulse appears.
module tb_psram_arb;
  import psram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;

  psram_arb_if #(.NUM_REQ(4)) bus ();

  psram_arb #(
    .NUM_REQ (4),
    .TIMEOUT (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ready;
    logic [31:0] rdata;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.req_addr_i[32*idx +: 32] = addr;
    bus.req_wdata_i[32*idx +: 32] = wdata;
    bus.req_wstrb_i[4*idx +: 4]   = wstrb;
  endtask

  // Wait (bounded) for the downstream request and check its address
  task automatic wait_busy(input logic [31:0] exp_addr);
    int n = 0;
    while (!bus.mem_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mem_valid", 32'(bus.mem_valid_o), 32'd1);
    chk("mem_addr", bus.mem_addr_o, exp_addr);
  endtask

  // Answer the downstream request lat cycles after mem_valid was first seen
  task automatic respond(input int lat, input logic [31:0] rd);
    repeat (lat - 1) @(negedge clk);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = rd;
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = 32'h0000_0000;
  endtask

  // Ready must already be up; compare against the scoreboard, then check pulse width
  task automatic expect_ready();
    sb_t e;
    int  n = 0;
    while (bus.req_ready_o == 4'b0000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_latency", 32'(n), 32'd0);
    chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("ready_vec", 32'(bus.req_ready_o), 32'(e.ready));
      chk("req_rdata", bus.req_rdata_o, e.rdata);
    end else begin
      e = '0;
    end
    @(negedge clk);
    chk("ready_one_cycle", 32'(bus.req_ready_o), 32'd0);
  endtask

  initial begin
    int n;
    sb_t e;

    rst             = 1'b1;
    bus.req_valid_i = 4'b0000;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_wstrb_i = '0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = 32'h0000_0000;
    bus.err_clr_i   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_valid", 32'(bus.mem_valid_o), 32'd0);
    chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_err_id", 32'(bus.err_id_o), 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0000_0000);

    // Contention: req0/req1 both held, grants must alternate starting at 0
    set_req(0, 32'h0000_1000, 32'h0, 4'h0);
    set_req(1, 32'h0000_1100, 32'h0, 4'h0);
    bus.req_valid_i = 4'b0011;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.ready = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      e.rdata = 32'hA000_0000 + 32'(i);
      sb_q.push_back(e);
      wait_busy((i % 2 == 0) ? 32'h0000_1000 : 32'h0000_1100);
      respond(1, e.rdata);
      expect_ready();
    end
    bus.req_valid_i = 4'b0000;

    // mem_ready while idle is ignored
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h1357_9BDF;
    repeat (2) @(negedge clk);
    chk("idle_ready_ignored", 32'(bus.req_ready_o), 32'd0);
    chk("idle_no_valid", 32'(bus.mem_valid_o), 32'd0);
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = 32'h0000_0000;

    // Single read from req0, downstream answers 3 cycles into BUSY
    set_req(0, 32'h0000_0100, 32'h0, 4'h0);
    bus.req_valid_i = 4'b0001;
    sb_q.push_back('{ready: 4'b0001, rdata: 32'hDEAD_BEEF});
    wait_busy(32'h0000_0100);
    chk("read_wstrb", 32'(bus.mem_wstrb_o), 32'd0);
    respond(3, 32'hDEAD_BEEF);
    expect_ready();
    bus.req_valid_i = 4'b0000;
    chk("read_valid_dropped", 32'(bus.mem_valid_o), 32'd0);

    // Write latching on req1: source data changes during BUSY
    set_req(1, 32'h0000_0200, 32'h1234_5678, 4'h3);
    bus.req_valid_i = 4'b0010;
    sb_q.push_back('{ready: 4'b0010, rdata: 32'h0000_0000});
    wait_busy(32'h0000_0200);
    chk("wr_wdata", bus.mem_wdata_o, 32'h1234_5678);
    chk("wr_wstrb", 32'(bus.mem_wstrb_o), 32'h3);
    set_req(1, 32'h0000_0204, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    chk("wr_wdata_held", bus.mem_wdata_o, 32'h1234_5678);
    chk("wr_wstrb_held", 32'(bus.mem_wstrb_o), 32'h3);
    chk("wr_addr_held", bus.mem_addr_o, 32'h0000_0200);
    respond(1, 32'h0000_0000);
    expect_ready();
    bus.req_valid_i = 4'b0000;

    // Watchdog timeout on req3: mem_ready never comes
    set_req(3, 32'h0000_0300, 32'h0, 4'h0);
    bus.req_valid_i = 4'b1000;
    sb_q.push_back('{ready: 4'b1000, rdata: ERR_RDATA});
    wait_busy(32'h0000_0300);
    n = 0;
    while (bus.mem_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_valid_cycles", 32'(n), 32'd8);
    chk("timeout_err_set", 32'(bus.err_o), 32'd1);
    chk("timeout_err_id", 32'(bus.err_id_o), 32'd3);
    expect_ready();
    bus.req_valid_i = 4'b0000;
    chk("err_sticky", 32'(bus.err_o), 32'd1);
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0;
    chk("err_cleared", 32'(bus.err_o), 32'd0);
    chk("err_id_kept", 32'(bus.err_id_o), 32'd3);

    // Reset in the middle of a BUSY transaction
    set_req(2, 32'h0000_02A0, 32'h0, 4'h0);
    bus.req_valid_i = 4'b0100;
    wait_busy(32'h0000_02A0);
    rst = 1'b1;
    bus.req_valid_i = 4'b0101;
    @(negedge clk);
    chk("midrst_mem_valid", 32'(bus.mem_valid_o), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("midrst_err", 32'(bus.err_o), 32'd0);
    chk("midrst_err_id", 32'(bus.err_id_o), 32'd0);
    rst = 1'b0;
    sb_q.push_back('{ready: 4'b0001, rdata: 32'h1111_2222});
    wait_busy(32'h0000_0100);
    respond(2, 32'h1111_2222);
    expect_ready();

    // req2 drops valid during BUSY; transaction still completes
    bus.req_valid_i = 4'b0100;
    wait_busy(32'h0000_02A0);
    bus.req_valid_i = 4'b0000;
    sb_q.push_back('{ready: 4'b0100, rdata: 32'h55AA_55AA});
    respond(2, 32'h55AA_55AA);
    expect_ready();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_idle_valid", 32'(bus.mem_valid_o), 32'd0);
      chk("drop_idle_ready", 32'(bus.req_ready_o), 32'd0);
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
